// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: idle flags, opening/closing flags, LSB-first data
// with zero-bit insertion after five consecutive ones, and abort sequences.
// The control registers describe the bit currently on the line; the next
// line bit is computed from them each cycle.
module hdlc_tx_framer #(
  parameter int MIN_FLAGS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       abort,
  output logic       out,
  output logic       out_flag,
  output logic       out_stuff,
  output logic       busy,
  output logic       underrun,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, DATA, CLOSE, ABORT} state_t;

  state_t     state, state_nx;
  logic [2:0] idx, idx_nx, idx_inc;
  logic [3:0] flag_cnt, flag_cnt_nx;
  logic [2:0] ones, ones_nx;
  logic       last, last_nx;
  logic [7:0] data, data_nx;
  logic       out_nx, out_flag_nx, out_stuff_nx;
  logic       flag_end, final_slot, load, owe_stuff;

  // Flag pattern in time order: 0,1,1,1,1,1,1,0
  function automatic logic flag_bit(input logic [2:0] i);
    return (i != 3'd0) && (i != 3'd7);
  endfunction

  // Completed-flag count saturates at the minimum needed to start a frame
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    if (c >= 4'(MIN_FLAGS)) return 4'(MIN_FLAGS);
    else                    return c + 4'd1;
  endfunction

  // Load points and status decoded from the bit currently on the line
  always_comb begin
    idx_inc    = idx + 3'd1;
    owe_stuff  = !out_stuff && (ones == 3'd5);
    flag_end   = ((state == IDLE) || (state == CLOSE)) && out_flag && (idx == 3'd7);
    final_slot = (state == DATA) && (idx == 3'd7) && !owe_stuff;
    s_ready    = (flag_end && (flag_cnt >= 4'(MIN_FLAGS))) || (final_slot && !last);
    load       = s_ready && s_valid;
    underrun   = final_slot && !last && !s_valid;
    frame_done = (state == CLOSE) && (idx == 3'd7);
    busy       = (state != IDLE);
  end

  // Next line bit and next state
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    flag_cnt_nx  = flag_cnt;
    ones_nx      = ones;
    last_nx      = last;
    data_nx      = data;
    out_nx       = 1'b0;
    out_flag_nx  = 1'b0;
    out_stuff_nx = 1'b0;
    if ((state == DATA) && abort) begin
      // Abort wins over a simultaneous underrun or byte load
      state_nx = ABORT;
      idx_nx   = 3'd0;
      out_nx   = 1'b1;
      ones_nx  = 3'd0;
    end else if (load) begin
      // Ones run carries over from the previous byte (zero after a flag)
      state_nx = DATA;
      idx_nx   = 3'd0;
      data_nx  = s_data;
      last_nx  = s_last;
      out_nx   = s_data[0];
      ones_nx  = s_data[0] ? ones + 3'd1 : 3'd0;
    end else begin
      case (state)
        IDLE: begin
          idx_nx      = (!out_flag || (idx == 3'd7)) ? 3'd0 : idx_inc;
          out_nx      = flag_bit(idx_nx);
          out_flag_nx = 1'b1;
          ones_nx     = 3'd0;
          if (idx_nx == 3'd7) flag_cnt_nx = sat_inc(flag_cnt);
        end
        CLOSE: begin
          if (idx == 3'd7) begin
            state_nx = IDLE;
            idx_nx   = 3'd0;
          end else begin
            idx_nx = idx_inc;
            if (idx_inc == 3'd7) flag_cnt_nx = 4'd1;
          end
          out_nx      = flag_bit(idx_nx);
          out_flag_nx = 1'b1;
          ones_nx     = 3'd0;
        end
        DATA: begin
          if (owe_stuff) begin
            out_nx       = 1'b0;
            out_stuff_nx = 1'b1;
            ones_nx      = 3'd0;
          end else if (idx != 3'd7) begin
            idx_nx  = idx_inc;
            out_nx  = data[idx_inc];
            ones_nx = data[idx_inc] ? ones + 3'd1 : 3'd0;
          end else if (last) begin
            state_nx    = CLOSE;
            idx_nx      = 3'd0;
            out_nx      = 1'b0;
            out_flag_nx = 1'b1;
            ones_nx     = 3'd0;
          end else begin
            // Underrun: no byte available at the final slot
            state_nx = ABORT;
            idx_nx   = 3'd0;
            out_nx   = 1'b1;
            ones_nx  = 3'd0;
          end
        end
        ABORT: begin
          ones_nx = 3'd0;
          if (idx == 3'd6) begin
            state_nx    = IDLE;
            idx_nx      = 3'd0;
            out_nx      = 1'b0;
            out_flag_nx = 1'b1;
            flag_cnt_nx = 4'd0;
          end else begin
            idx_nx = idx_inc;
            out_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Control state and registered line outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      flag_cnt  <= 4'd0;
      ones      <= 3'd0;
      last      <= 1'b0;
      out       <= 1'b0;
      out_flag  <= 1'b0;
      out_stuff <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      flag_cnt  <= flag_cnt_nx;
      ones      <= ones_nx;
      last      <= last_nx;
      out       <= out_nx;
      out_flag  <= out_flag_nx;
      out_stuff <= out_stuff_nx;
    end
  end

  // Byte holding register (data path, not reset)
  always_ff @(posedge clk) begin
    data <= data_nx;
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: idle flags, stuffing, byte chaining,
// underrun, abort and asynchronous reset.
module tb_hdlc_tx_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data, s_data2;
  logic       s_valid, s_valid2, s_last, s_last2, abort, abort2;
  logic       s_ready, out, out_flag, out_stuff, busy, underrun, frame_done;
  logic       s_ready2, out2, out_flag2, out_stuff2, busy2, underrun2, frame_done2;

  int tests = 0;
  int fails = 0;

  logic [63:0] r_out, r_stuff, r_flag, r_rdy, r_fd, r_busy, r_und;
  int          n;
  logic [7:0]  bytes [0:3];

  always #5 clk = ~clk;

  hdlc_tx_framer #(.MIN_FLAGS(1)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .abort(abort), .out(out), .out_flag(out_flag),
    .out_stuff(out_stuff), .busy(busy), .underrun(underrun), .frame_done(frame_done)
  );

  hdlc_tx_framer #(.MIN_FLAGS(2)) dut2 (
    .clk(clk), .reset(reset), .s_data(s_data2), .s_valid(s_valid2), .s_last(s_last2),
    .s_ready(s_ready2), .abort(abort2), .out(out2), .out_flag(out_flag2),
    .out_stuff(out_stuff2), .busy(busy2), .underrun(underrun2), .frame_done(frame_done2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rec_clear();
    r_out = '0; r_stuff = '0; r_flag = '0; r_rdy = '0; r_fd = '0; r_busy = '0; r_und = '0;
    n = 0;
  endtask

  // Shift in the current dut outputs; first recorded bit ends up most significant
  task automatic rec1();
    r_out   = {r_out[62:0], out};
    r_stuff = {r_stuff[62:0], out_stuff};
    r_flag  = {r_flag[62:0], out_flag};
    r_rdy   = {r_rdy[62:0], s_ready};
    r_fd    = {r_fd[62:0], frame_done};
    r_busy  = {r_busy[62:0], busy};
    r_und   = {r_und[62:0], underrun};
    n++;
  endtask

  // Offer nb bytes from 'bytes' and record the line from the first data bit
  // through the frame_done cycle
  task automatic run_frame(input int nb, input int maxc);
    int k = 0;
    int c = 0;
    bit started = 0;
    bit done = 0;
    bit acc;
    rec_clear();
    s_data = bytes[0]; s_last = (nb == 1); s_valid = 1'b1;
    while (c < maxc) begin
      acc = s_ready && s_valid;
      wait_cyc();
      c++;
      if (acc) begin
        k++;
        started = 1;
        if (k < nb) begin
          s_data = bytes[k]; s_last = (k == nb - 1);
        end else begin
          s_valid = 1'b0; s_last = 1'b0;
        end
      end
      if (started) begin
        rec1();
        if (frame_done) begin
          done = 1;
          break;
        end
      end
    end
    s_valid = 1'b0;
    check("frame_timeout", 64'(done), 64'd1);
  endtask

  // Wait (bounded) for dut to accept the byte currently offered
  task automatic wait_accept(input string tag);
    bit acc;
    bit ok = 0;
    for (int c = 0; c < 64; c++) begin
      acc = s_ready && s_valid;
      wait_cyc();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    s_valid = 1'b0;
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    s_data = '0; s_valid = 0; s_last = 0; abort = 0;
    s_data2 = '0; s_valid2 = 0; s_last2 = 0; abort2 = 0;
    wait_cyc();
    wait_cyc();
    check("rst_out", 64'(out), 0);
    check("rst_flag", 64'(out_flag), 0);
    check("rst_stuff", 64'(out_stuff), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_ready", 64'(s_ready), 0);
    check("rst_under", 64'(underrun), 0);
    check("rst_done", 64'(frame_done), 0);

    // Idle flags after reset release
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wait_cyc();
      check("idle_out", 64'(out), 64'((i % 8 != 0) && (i % 8 != 7)));
      check("idle_flag", 64'(out_flag), 1);
      check("idle_busy", 64'(busy), 0);
      check("idle_ready", 64'(s_ready), 64'(i % 8 == 7));
    end

    // Single byte 0xFF, last
    bytes[0] = 8'hFF;
    run_frame(1, 100);
    check("ff_len", 64'(n), 17);
    check("ff_out", r_out, 17'b11111011101111110);
    check("ff_stuff", r_stuff, 17'b00000100000000000);
    check("ff_flag", r_flag, 17'b00000000011111111);
    check("ff_done", r_fd, 17'b00000000000000001);
    check("ff_ready", r_rdy, 17'b00000000000000001);

    // 0xF8 then 0x03 (last): stuff after bit 7, next byte loaded in stuff slot
    bytes[0] = 8'hF8; bytes[1] = 8'h03;
    run_frame(2, 100);
    check("f803_len", 64'(n), 25);
    check("f803_out", r_out, 25'b0001111101100000001111110);
    check("f803_stuff", r_stuff, 25'b0000000010000000000000000);
    check("f803_ready", r_rdy, 25'b0000000010000000000000001);
    check("f803_flag", r_flag, 25'b0000000000000000011111111);
    check("f803_done", r_fd, 25'b0000000000000000000000001);

    // 0x1F, abort raised while bit 3 is on the line (starts off the shared flag)
    s_data = 8'h1F; s_last = 1'b0; s_valid = 1'b1;
    wait_accept("abort_accept");
    rec_clear();
    for (int i = 0; i < 19; i++) begin
      if (i > 0) wait_cyc();
      rec1();
      abort = (i == 3);
    end
    abort = 1'b0;
    check("abort_out", r_out, 19'b1111111111101111110);
    check("abort_busy", r_busy, 19'b1111111111100000000);
    check("abort_flag", r_flag, 19'b0000000000011111111);
    check("abort_stuff", r_stuff, 64'd0);
    check("abort_done", r_fd, 64'd0);

    // Abort while idle has no effect
    abort = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_cyc();
      check("idle_abort_busy", 64'(busy), 0);
      check("idle_abort_flag", 64'(out_flag), 1);
    end
    abort = 1'b0;

    // Underrun on the MIN_FLAGS=2 instance
    s_data2 = 8'h00; s_last2 = 1'b0; s_valid2 = 1'b1;
    begin
      bit acc;
      bit ok = 0;
      for (int c = 0; c < 64; c++) begin
        acc = s_ready2 && s_valid2;
        wait_cyc();
        if (acc) begin
          ok = 1;
          break;
        end
      end
      s_valid2 = 1'b0;
      check("under_accept", 64'(ok), 1);
    end
    rec_clear();
    for (int i = 0; i < 31; i++) begin
      if (i > 0) wait_cyc();
      r_out  = {r_out[62:0], out2};
      r_und  = {r_und[62:0], underrun2};
      r_rdy  = {r_rdy[62:0], s_ready2};
      r_busy = {r_busy[62:0], busy2};
    end
    check("under_out", r_out, 31'b0000000011111110111111001111110);
    check("under_pulse", r_und, 31'b0000000100000000000000000000000);
    check("under_ready", r_rdy, 31'b0000000100000000000000000000001);
    check("under_busy", r_busy, 31'b1111111111111110000000000000000);

    // Asynchronous reset in the middle of a data byte
    s_data = 8'h55; s_last = 1'b1; s_valid = 1'b1;
    wait_accept("rst_accept");
    wait_cyc();
    wait_cyc();
    check("pre_rst_busy", 64'(busy), 1);
    check("pre_rst_out", 64'(out), 1);
    #2 reset = 1'b1;
    #1;
    check("async_out", 64'(out), 0);
    check("async_busy", 64'(busy), 0);
    check("async_ready", 64'(s_ready), 0);
    check("async_flag", 64'(out_flag), 0);
    #3 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_cyc();
      check("post_rst_out", 64'(out), 64'((i != 0) && (i != 7)));
      check("post_rst_done", 64'(frame_done), 0);
    end

    // Fresh frame after reset
    bytes[0] = 8'hFF;
    run_frame(1, 100);
    check("ff2_len", 64'(n), 17);
    check("ff2_out", r_out, 17'b11111011101111110);
    check("ff2_stuff", r_stuff, 17'b00000100000000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
